// File: rtl/cache_mem_port_arbiter.sv
// rtl/cache_mem_port_arbiter.sv - two cache ports sharing one memory port, round-robin grant, in-order response routing
// Optional burst lock compiled in with `define CACHE_MEM_ARB_LOCK_EN.

module cache_mem_port_arbiter #(
   parameter int REQ_W           = 77,
   parameter int RESP_W          = 47,
   parameter int MAX_OUTSTANDING = 4,
   parameter int BURST_LEN       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_val,
   output logic              req0_rdy,
   input  logic [REQ_W-1:0]  req0_msg,
   output logic              resp0_val,
   input  logic              resp0_rdy,
   output logic [RESP_W-1:0] resp0_msg,
   input  logic              req1_val,
   output logic              req1_rdy,
   input  logic [REQ_W-1:0]  req1_msg,
   output logic              resp1_val,
   input  logic              resp1_rdy,
   output logic [RESP_W-1:0] resp1_msg,
   output logic              mem_req_val,
   input  logic              mem_req_rdy,
   output logic [REQ_W-1:0]  mem_req_msg,
   input  logic              mem_resp_val,
   output logic              mem_resp_rdy,
   input  logic [RESP_W-1:0] mem_resp_msg,
   output logic              busy
);

   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam bit CFG_OK = (MAX_OUTSTANDING >= 2) &&
                           ((MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) == 0) &&
                           (BURST_LEN >= 1);

   generate
      if (!CFG_OK) begin : g_bad_cfg
         $error("cache_mem_port_arbiter: MAX_OUTSTANDING must be a power of two >= 2, BURST_LEN >= 1");
      end
   endgenerate

   logic                       prio;
   logic [MAX_OUTSTANDING-1:0] id_fifo;
   logic [PTR_W-1:0]           head;
   logic [PTR_W-1:0]           tail;
   logic [CNT_W-1:0]           count;
   logic                       full;
   logic                       empty;
   logic                       grant;
   logic                       sel_val;
   logic                       head_id;
   logic                       req_fire;
   logic                       resp_fire;
   logic                       prio_update;

   assign full  = (count == CNT_W'(MAX_OUTSTANDING));
   assign empty = (count == '0);

`ifdef CACHE_MEM_ARB_LOCK_EN
   localparam int BEAT_W = ($clog2(BURST_LEN) < 2) ? 2 : $clog2(BURST_LEN);

   logic [BEAT_W-1:0] beat_cnt;
   logic              lock_owner;
   logic              locked;

   // A nonzero beat count means a burst is in progress and the grant is pinned to its owner.
   assign locked      = (beat_cnt != '0);
   assign grant       = locked ? lock_owner : ((req0_val & req1_val) ? prio : req1_val);
   assign prio_update = req_fire & (beat_cnt == BEAT_W'(BURST_LEN - 1));

   // Count beats of the current burst and capture its owner on the first beat.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt   <= '0;
         lock_owner <= 1'b0;
      end else if (req_fire) begin
         if (beat_cnt == BEAT_W'(BURST_LEN - 1))
            beat_cnt <= '0;
         else
            beat_cnt <= beat_cnt + 1'b1;
         if (!locked)
            lock_owner <= grant;
      end
   end
`else
   assign grant       = (req0_val & req1_val) ? prio : req1_val;
   assign prio_update = req_fire;
`endif

   // Request side: the granted port passes straight through; a full ID FIFO blocks everything,
   // deliberately ignoring a same-cycle pop so mem_resp never reaches mem_req_rdy combinationally.
   assign sel_val     = grant ? req1_val : req0_val;
   assign mem_req_val = reset & sel_val & ~full;
   assign mem_req_msg = grant ? req1_msg : req0_msg;
   assign req0_rdy    = reset & mem_req_rdy & ~full & ~grant;
   assign req1_rdy    = reset & mem_req_rdy & ~full & grant;
   assign req_fire    = mem_req_val & mem_req_rdy;

   // Response side: the head ID picks the destination; an empty FIFO stalls stray responses.
   assign head_id      = id_fifo[head];
   assign resp0_val    = reset & mem_resp_val & ~empty & ~head_id;
   assign resp1_val    = reset & mem_resp_val & ~empty & head_id;
   assign resp0_msg    = mem_resp_msg;
   assign resp1_msg    = mem_resp_msg;
   assign mem_resp_rdy = reset & ~empty & (head_id ? resp1_rdy : resp0_rdy);
   assign resp_fire    = mem_resp_val & mem_resp_rdy;

   assign busy = ~empty;

   // Track in-flight request owners and rotate priority away from the port just served.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prio    <= 1'b0;
         id_fifo <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
      end else begin
         if (req_fire) begin
            id_fifo[tail] <= grant;
            tail          <= tail + 1'b1;
         end
         if (prio_update)
            prio <= ~grant;
         if (resp_fire)
            head <= head + 1'b1;
         case ({req_fire, resp_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_mem_port_arbiter.sv
// tb/tb_cache_mem_port_arbiter.sv - scoreboard bench for cache_mem_port_arbiter

module tb_cache_mem_port_arbiter;

   localparam int REQ_W  = 77;
   localparam int RESP_W = 47;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0_val, req0_rdy, resp0_val, resp0_rdy;
   logic              req1_val, req1_rdy, resp1_val, resp1_rdy;
   logic [REQ_W-1:0]  req0_msg, req1_msg, mem_req_msg;
   logic [RESP_W-1:0] resp0_msg, resp1_msg, mem_resp_msg;
   logic              mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy, busy;

   int checks = 0;
   int errors = 0;

   logic [REQ_W-1:0]  q_mem_req[$];
   logic [RESP_W-1:0] q_resp0[$];
   logic [RESP_W-1:0] q_resp1[$];

   always #5 clk = ~clk;

   cache_mem_port_arbiter #(
      .REQ_W(REQ_W), .RESP_W(RESP_W), .MAX_OUTSTANDING(4), .BURST_LEN(4)
   ) dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
      .busy(busy)
   );

   function automatic logic [REQ_W-1:0] mk_req(input logic [31:0] addr, input logic [7:0] op);
      return {5'h0, op, addr, 32'h0};
   endfunction

   function automatic logic [RESP_W-1:0] mk_resp(input logic [31:0] data, input logic [7:0] op);
      return {7'h0, op, data};
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0_val     = 1'b0;
      req1_val     = 1'b0;
      mem_resp_val = 1'b0;
      mem_req_rdy  = 1'b1;
      resp0_rdy    = 1'b1;
      resp1_rdy    = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic send_req(input bit port, input logic [REQ_W-1:0] m);
      if (port) begin req1_val = 1'b1; req1_msg = m; end
      else      begin req0_val = 1'b1; req0_msg = m; end
      q_mem_req.push_back(m);
      tick();
      req0_val = 1'b0;
      req1_val = 1'b0;
   endtask

   task automatic send_resp(input logic [RESP_W-1:0] m, input bit port);
      mem_resp_val = 1'b1;
      mem_resp_msg = m;
      if (port) q_resp1.push_back(m);
      else      q_resp0.push_back(m);
      tick();
      mem_resp_val = 1'b0;
   endtask

   // Monitor: pop the scoreboard on every observed transfer.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (mem_req_val && mem_req_rdy) begin
            checks++;
            if (q_mem_req.size() == 0) begin
               errors++;
               $display("FAIL mem_req_unexpected actual=%0h expected=none", mem_req_msg);
            end else begin
               checks--;
               chk("mem_req_msg", 80'(mem_req_msg), 80'(q_mem_req.pop_front()));
            end
         end
         if (resp0_val && resp0_rdy) begin
            checks++;
            if (q_resp0.size() == 0) begin
               errors++;
               $display("FAIL resp0_unexpected actual=%0h expected=none", resp0_msg);
            end else begin
               checks--;
               chk("resp0_msg", 80'(resp0_msg), 80'(q_resp0.pop_front()));
            end
         end
         if (resp1_val && resp1_rdy) begin
            checks++;
            if (q_resp1.size() == 0) begin
               errors++;
               $display("FAIL resp1_unexpected actual=%0h expected=none", resp1_msg);
            end else begin
               checks--;
               chk("resp1_msg", 80'(resp1_msg), 80'(q_resp1.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int g_tbl[4];
      int p_tbl[4];
      int id_q[$];
      int n0, n1, hid;

      req0_msg     = '0;
      req1_msg     = '0;
      mem_resp_msg = '0;
      reset        = 1'b0;
      idle();
      #1;
      chk("rst_mem_req_val", 80'(mem_req_val), 80'(0));
      chk("rst_req0_rdy", 80'(req0_rdy), 80'(0));
      chk("rst_busy", 80'(busy), 80'(0));

      // Test 1: single port 0 read
      do_reset();
      chk("t1_idle_mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
      req0_val = 1'b1;
      req0_msg = mk_req(32'h1000, 8'h05);
      q_mem_req.push_back(req0_msg);
      #1;
      chk("t1_mem_req_val", 80'(mem_req_val), 80'(1));
      chk("t1_req0_rdy", 80'(req0_rdy), 80'(1));
      chk("t1_req1_rdy", 80'(req1_rdy), 80'(0));
      tick();
      req0_val = 1'b0;
      chk("t1_busy", 80'(busy), 80'(1));
      mem_resp_val = 1'b1;
      mem_resp_msg = mk_resp(32'hDEADBEEF, 8'h05);
      q_resp0.push_back(mem_resp_msg);
      #1;
      chk("t1_resp0_val", 80'(resp0_val), 80'(1));
      chk("t1_resp1_val", 80'(resp1_val), 80'(0));
      tick();
      mem_resp_val = 1'b0;
      chk("t1_busy_after", 80'(busy), 80'(0));

      // Test 2: both ports requesting every cycle
      do_reset();
`ifdef CACHE_MEM_ARB_LOCK_EN
      g_tbl = '{0, 0, 0, 0};
`else
      g_tbl = '{0, 1, 0, 1};
`endif
      n0 = 0;
      n1 = 0;
      for (int i = 0; i < 4; i++) begin
         req0_val = 1'b1;
         req1_val = 1'b1;
         req0_msg = mk_req(32'h2000 + n0 * 4, 8'h10 + 8'(n0));
         req1_msg = mk_req(32'h3000 + n1 * 4, 8'h20 + 8'(n1));
         if (g_tbl[i] == 0) begin q_mem_req.push_back(req0_msg); n0++; end
         else               begin q_mem_req.push_back(req1_msg); n1++; end
         tick();
      end
      req0_val = 1'b0;
      req1_val = 1'b0;
      chk("t2_busy", 80'(busy), 80'(1));
      for (int i = 0; i < 4; i++)
         send_resp(mk_resp(32'hA000_0000 + i, 8'h30 + 8'(i)), g_tbl[i][0]);
      chk("t2_busy_after", 80'(busy), 80'(0));

      // Test 3: full FIFO blocks, even with a same-cycle pop
      do_reset();
      for (int i = 0; i < 4; i++)
         send_req(1'b0, mk_req(32'h4000 + i * 4, 8'h40 + 8'(i)));
      req0_val = 1'b1;
      req0_msg = mk_req(32'h4010, 8'h44);
      q_mem_req.push_back(req0_msg);
      #1;
      chk("t3_full_req0_rdy", 80'(req0_rdy), 80'(0));
      chk("t3_full_mem_req_val", 80'(mem_req_val), 80'(0));
      chk("t3_full_busy", 80'(busy), 80'(1));
      mem_resp_val = 1'b1;
      mem_resp_msg = mk_resp(32'hB000_0000, 8'h40);
      q_resp0.push_back(mem_resp_msg);
      #1;
      chk("t3_pop_mem_resp_rdy", 80'(mem_resp_rdy), 80'(1));
      chk("t3_pop_mem_req_val", 80'(mem_req_val), 80'(0));
      tick();
      mem_resp_val = 1'b0;
      #1;
      chk("t3_after_req0_rdy", 80'(req0_rdy), 80'(1));
      chk("t3_after_mem_req_val", 80'(mem_req_val), 80'(1));
      tick();
      req0_val = 1'b0;
      for (int i = 0; i < 4; i++)
         send_resp(mk_resp(32'hB000_0001 + i, 8'h41 + 8'(i)), 1'b0);
      chk("t3_busy_after", 80'(busy), 80'(0));

      // Test 4: head owner 1 not ready stalls the memory response
      do_reset();
      send_req(1'b1, mk_req(32'h5000, 8'h50));
      resp0_rdy    = 1'b1;
      resp1_rdy    = 1'b0;
      mem_resp_val = 1'b1;
      mem_resp_msg = mk_resp(32'hC0FF_EE00, 8'h50);
      #1;
      chk("t4_stall_mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
      chk("t4_stall_resp0_val", 80'(resp0_val), 80'(0));
      chk("t4_stall_resp1_val", 80'(resp1_val), 80'(1));
      tick();
      chk("t4_stall_busy", 80'(busy), 80'(1));
      resp1_rdy = 1'b1;
      q_resp1.push_back(mem_resp_msg);
      #1;
      chk("t4_go_mem_resp_rdy", 80'(mem_resp_rdy), 80'(1));
      tick();
      mem_resp_val = 1'b0;
      chk("t4_busy_after", 80'(busy), 80'(0));

      // Test 5: push and pop together at count 2, crossing the tail wrap
      do_reset();
      send_req(1'b0, mk_req(32'h6000, 8'h60));
      send_req(1'b1, mk_req(32'h6004, 8'h61));
      id_q  = '{0, 1};
      p_tbl = '{0, 1, 1, 0};
      for (int k = 0; k < 4; k++) begin
         if (p_tbl[k] == 1) begin req1_val = 1'b1; req1_msg = mk_req(32'h6100 + k * 4, 8'h70 + 8'(k)); q_mem_req.push_back(req1_msg); end
         else               begin req0_val = 1'b1; req0_msg = mk_req(32'h6100 + k * 4, 8'h70 + 8'(k)); q_mem_req.push_back(req0_msg); end
         mem_resp_val = 1'b1;
         mem_resp_msg = mk_resp(32'hD000_0000 + k, 8'h80 + 8'(k));
         hid = id_q.pop_front();
         id_q.push_back(p_tbl[k]);
         if (hid == 1) q_resp1.push_back(mem_resp_msg);
         else          q_resp0.push_back(mem_resp_msg);
         #1;
         chk("t5_mem_req_val", 80'(mem_req_val), 80'(1));
         chk("t5_mem_resp_rdy", 80'(mem_resp_rdy), 80'(1));
         tick();
         req0_val     = 1'b0;
         req1_val     = 1'b0;
         mem_resp_val = 1'b0;
         chk("t5_busy", 80'(busy), 80'(1));
      end
      for (int k = 0; k < 2; k++) begin
         hid = id_q.pop_front();
         send_resp(mk_resp(32'hE000_0000 + k, 8'h90 + 8'(k)), hid[0]);
         chk("t5_drain_busy", 80'(busy), 80'(k == 0));
      end

      // Test 6: asynchronous reset with 3 outstanding
      do_reset();
      for (int i = 0; i < 3; i++)
         send_req(1'b0, mk_req(32'h7000 + i * 4, 8'hA0 + 8'(i)));
      req0_val     = 1'b1;
      req0_msg     = mk_req(32'h700C, 8'hA3);
      mem_resp_val = 1'b1;
      mem_resp_msg = mk_resp(32'h1234_5678, 8'hA0);
      #1;
      chk("t6_pre_mem_req_val", 80'(mem_req_val), 80'(1));
      chk("t6_pre_busy", 80'(busy), 80'(1));
      reset = 1'b0;
      #1;
      chk("t6_rst_mem_req_val", 80'(mem_req_val), 80'(0));
      chk("t6_rst_req0_rdy", 80'(req0_rdy), 80'(0));
      chk("t6_rst_mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
      chk("t6_rst_resp0_val", 80'(resp0_val), 80'(0));
      chk("t6_rst_busy", 80'(busy), 80'(0));
      tick();
      tick();
      req0_val = 1'b0;
      reset    = 1'b1;
      #1;
      chk("t6_empty_mem_resp_rdy", 80'(mem_resp_rdy), 80'(0));
      chk("t6_empty_resp0_val", 80'(resp0_val), 80'(0));
      chk("t6_empty_resp1_val", 80'(resp1_val), 80'(0));
      chk("t6_empty_busy", 80'(busy), 80'(0));
      mem_resp_val = 1'b0;
      req0_val     = 1'b1;
      req1_val     = 1'b1;
      req0_msg     = mk_req(32'h7100, 8'hB0);
      req1_msg     = mk_req(32'h7200, 8'hB1);
      q_mem_req.push_back(req0_msg);
      #1;
      chk("t6_prio_req0_rdy", 80'(req0_rdy), 80'(1));
      chk("t6_prio_req1_rdy", 80'(req1_rdy), 80'(0));
      tick();
      req0_val = 1'b0;
      req1_val = 1'b0;
      send_resp(mk_resp(32'hF000_0000, 8'hB0), 1'b0);
      chk("t6_busy_after", 80'(busy), 80'(0));

      tick();
      chk("sb_mem_req_left", 80'(q_mem_req.size()), 80'(0));
      chk("sb_resp0_left", 80'(q_resp0.size()), 80'(0));
      chk("sb_resp1_left", 80'(q_resp1.size()), 80'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
